// File: rtl/mult_pipe_if.sv
// Issue/writeback bundle for mult_pipe: issue operands and controls in, registered writeback out.
// The master modport is the issue/writeback side, the slave modport is the multiplier itself.
interface mult_pipe_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5,
  parameter int CNTW  = 3
);
  logic             iss_mul_oper;
  logic             iss_mul_signed;
  logic             iss_mul_high;
  logic [WIDTH-1:0] iss_mul_rega;
  logic [WIDTH-1:0] iss_mul_regb;
  logic [REGW-1:0]  iss_mul_regdest;
  logic             wb_mul_stall;
  logic             mul_flush;
  logic             mul_iss_ready;
  logic             mul_wb_oper;
  logic             mul_wb_writereg;
  logic [REGW-1:0]  mul_wb_regdest;
  logic [WIDTH-1:0] mul_wb_wbvalue;
  logic [CNTW-1:0]  mul_inflight;

  modport master (
    output iss_mul_oper, iss_mul_signed, iss_mul_high, iss_mul_rega, iss_mul_regb,
           iss_mul_regdest, wb_mul_stall, mul_flush,
    input  mul_iss_ready, mul_wb_oper, mul_wb_writereg, mul_wb_regdest, mul_wb_wbvalue,
           mul_inflight
  );

  modport slave (
    input  iss_mul_oper, iss_mul_signed, iss_mul_high, iss_mul_rega, iss_mul_regb,
           iss_mul_regdest, wb_mul_stall, mul_flush,
    output mul_iss_ready, mul_wb_oper, mul_wb_writereg, mul_wb_regdest, mul_wb_wbvalue,
           mul_inflight
  );
endinterface

// File: rtl/mult_pipe.sv
// Pipelined WIDTHxWIDTH multiplier, signed/unsigned, high/low half; fixed STAGES-cycle latency.
// wb_mul_stall freezes every slot and deasserts mul_iss_ready; mul_flush clears all valids.
module mult_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int REGW   = 5
) (
  input logic        clock,
  input logic        reset,
  mult_pipe_if.slave bus
);
  localparam int CNTW = $clog2(STAGES + 1);
  localparam int PW   = 2 * WIDTH;

  logic [STAGES:1]   r_vld;
  logic [STAGES-1:1] r_hi;
  logic              r_sgn;
  logic [WIDTH-1:0]  r_opa;
  logic [WIDTH-1:0]  r_opb;
  logic [REGW-1:0]   r_dst [1:STAGES];
  logic [WIDTH-1:0]  r_wbval;
  logic [CNTW-1:0]   r_cnt;

  logic [PW-1:0]     w_exta;
  logic [PW-1:0]     w_extb;
  logic [PW-1:0]     w_prod1;
  logic [PW-1:0]     w_full;

  // Slot 1 holds raw operands; the full product is formed on the way into slot 2.
  assign w_exta  = r_sgn ? {{WIDTH{r_opa[WIDTH-1]}}, r_opa} : {{WIDTH{1'b0}}, r_opa};
  assign w_extb  = r_sgn ? {{WIDTH{r_opb[WIDTH-1]}}, r_opb} : {{WIDTH{1'b0}}, r_opb};
  assign w_prod1 = w_exta * w_extb;

  always_ff @(posedge clock) begin
    if (!reset || bus.mul_flush) begin
      r_vld <= '0;
      r_cnt <= '0;
    end else if (!bus.wb_mul_stall) begin
      r_vld <= {r_vld[STAGES-1:1], bus.iss_mul_oper};
      r_cnt <= r_cnt + CNTW'(bus.iss_mul_oper) - CNTW'(r_vld[STAGES]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sgn   <= 1'b0;
      r_hi    <= '0;
      r_wbval <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        r_dst[k] <= '0;
      end
    end else if (!bus.wb_mul_stall) begin
      r_sgn    <= bus.iss_mul_signed;
      r_hi[1]  <= bus.iss_mul_high;
      for (int k = 2; k < STAGES; k++) begin
        r_hi[k] <= r_hi[k-1];
      end
      r_dst[1] <= bus.iss_mul_regdest;
      for (int k = 2; k <= STAGES; k++) begin
        r_dst[k] <= r_dst[k-1];
      end
      r_wbval  <= r_hi[STAGES-1] ? w_full[PW-1:WIDTH] : w_full[WIDTH-1:0];
    end
  end

  // Operand registers carry no reset: their contents only matter behind a valid bit.
  always_ff @(posedge clock) begin
    if (!bus.wb_mul_stall) begin
      r_opa <= bus.iss_mul_rega;
      r_opb <= bus.iss_mul_regb;
    end
  end

  if (STAGES > 2) begin : g_mid
    logic [PW-1:0] r_prod [2:STAGES-1];

    always_ff @(posedge clock) begin
      if (!bus.wb_mul_stall) begin
        r_prod[2] <= w_prod1;
        for (int k = 3; k < STAGES; k++) begin
          r_prod[k] <= r_prod[k-1];
        end
      end
    end

    assign w_full = r_prod[STAGES-1];
  end else begin : g_direct
    assign w_full = w_prod1;
  end

  assign bus.mul_iss_ready   = !bus.wb_mul_stall;
  assign bus.mul_wb_oper     = r_vld[STAGES];
  assign bus.mul_wb_writereg = r_vld[STAGES] && (r_dst[STAGES] != '0);
  assign bus.mul_wb_regdest  = r_dst[STAGES];
  assign bus.mul_wb_wbvalue  = r_wbval;
  assign bus.mul_inflight    = r_cnt;
endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe (WIDTH=32, STAGES=4): directed cases plus randomized traffic
// against a queue-based scoreboard that counts remaining unstalled edges per operation.
module tb_mult_pipe;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int REGW   = 5;
  localparam int CNTW   = 3;

  typedef struct {
    logic [WIDTH-1:0] val;
    logic [REGW-1:0]  dst;
    int               rem;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   zero_chk = 1'b0;
  ent_t q[$];

  always #5 clock = ~clock;

  mult_pipe_if #(.WIDTH(WIDTH), .REGW(REGW), .CNTW(CNTW)) bus ();

  mult_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .REGW(REGW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] calc(input logic sgn, input logic hi,
                                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint          sa;
    longint          sb;
    longint unsigned p;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      p  = longint'(sa * sb);
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    return hi ? p[63:32] : p[31:0];
  endfunction

  task automatic check_outputs();
    if (q.size() > 0 && q[0].rem == 0) begin
      chk("oper", 64'(bus.mul_wb_oper), 64'd1);
      chk("writereg", 64'(bus.mul_wb_writereg), 64'(q[0].dst != 0));
      chk("regdest", 64'(bus.mul_wb_regdest), 64'(q[0].dst));
      chk("wbvalue", 64'(bus.mul_wb_wbvalue), 64'(q[0].val));
    end else begin
      chk("oper_idle", 64'(bus.mul_wb_oper), 64'd0);
      chk("writereg_idle", 64'(bus.mul_wb_writereg), 64'd0);
    end
    if (zero_chk) begin
      chk("regdest_rst", 64'(bus.mul_wb_regdest), 64'd0);
      chk("wbvalue_rst", 64'(bus.mul_wb_wbvalue), 64'd0);
      zero_chk = 1'b0;
    end
    chk("inflight", 64'(bus.mul_inflight), 64'(q.size()));
  endtask

  // One clock: check current outputs, drive inputs, take the edge, then advance the model.
  task automatic cyc(input logic op, input logic sgn, input logic hi,
                     input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [REGW-1:0] d, input logic st, input logic fl, input logic rs);
    ent_t e;
    @(negedge clock);
    check_outputs();
    bus.iss_mul_oper    = op;
    bus.iss_mul_signed  = sgn;
    bus.iss_mul_high    = hi;
    bus.iss_mul_rega    = a;
    bus.iss_mul_regb    = b;
    bus.iss_mul_regdest = d;
    bus.wb_mul_stall    = st;
    bus.mul_flush       = fl;
    reset               = rs;
    #1;
    chk("iss_ready", 64'(bus.mul_iss_ready), 64'(!st));
    @(posedge clock);
    if (!rs) begin
      q.delete();
      zero_chk = 1'b1;
    end else if (fl) begin
      q.delete();
    end else if (!st) begin
      if (q.size() > 0 && q[0].rem == 0) void'(q.pop_front());
      foreach (q[i]) q[i].rem--;
      if (op) begin
        e.val = calc(sgn, hi, a, b);
        e.dst = d;
        e.rem = STAGES - 1;
        q.push_back(e);
      end
    end
  endtask

  task automatic iss(input logic sgn, input logic hi, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input logic [REGW-1:0] d);
    cyc(1'b1, sgn, hi, a, b, d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    logic             h_op, h_sgn, h_hi, st, fl, rs;
    logic [WIDTH-1:0] h_a, h_b;
    logic [REGW-1:0]  h_d;
    bit               need_new;

    bus.iss_mul_oper    = 1'b0;
    bus.iss_mul_signed  = 1'b0;
    bus.iss_mul_high    = 1'b0;
    bus.iss_mul_rega    = '0;
    bus.iss_mul_regb    = '0;
    bus.iss_mul_regdest = '0;
    bus.wb_mul_stall    = 1'b0;
    bus.mul_flush       = 1'b0;
    reset               = 1'b0;
    repeat (2) @(posedge clock);
    zero_chk = 1'b1;

    // Signed -3 x 7, low then high half.
    iss(1'b1, 1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 5'd5);
    idle(3);
    #1;
    chk("neg_lo_val", 64'(bus.mul_wb_wbvalue), 64'hFFFF_FFEB);
    chk("neg_lo_wr", 64'(bus.mul_wb_writereg), 64'd1);
    chk("neg_lo_dst", 64'(bus.mul_wb_regdest), 64'd5);
    iss(1'b1, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 5'd5);
    idle(3);
    #1;
    chk("neg_hi_val", 64'(bus.mul_wb_wbvalue), 64'hFFFF_FFFF);

    // All-ones operands in three flavours, issued back to back.
    iss(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    iss(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    iss(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    idle(1);
    #1 chk("ones_u_hi", 64'(bus.mul_wb_wbvalue), 64'hFFFF_FFFE);
    idle(1);
    #1 chk("ones_u_lo", 64'(bus.mul_wb_wbvalue), 64'h0000_0001);
    idle(1);
    #1 chk("ones_s_hi", 64'(bus.mul_wb_wbvalue), 64'h0000_0000);
    idle(1);

    // Four back-to-back squares with a two-cycle stall after the second result.
    for (int i = 1; i <= 4; i++) iss(1'b0, 1'b0, 32'(i), 32'(i), 5'(i));
    #1;
    chk("b2b_peak", 64'(bus.mul_inflight), 64'd4);
    chk("b2b_r1", 64'(bus.mul_wb_wbvalue), 64'd1);
    idle(1);
    #1 chk("b2b_r2", 64'(bus.mul_wb_wbvalue), 64'd4);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
      #1;
      chk("b2b_hold_val", 64'(bus.mul_wb_wbvalue), 64'd4);
      chk("b2b_hold_oper", 64'(bus.mul_wb_oper), 64'd1);
    end
    idle(1);
    #1 chk("b2b_r3", 64'(bus.mul_wb_wbvalue), 64'd9);
    idle(1);
    #1 chk("b2b_r4", 64'(bus.mul_wb_wbvalue), 64'd16);
    idle(1);
    #1 chk("b2b_done", 64'(bus.mul_wb_oper), 64'd0);

    // Flush with three in flight and a concurrent issue.
    for (int i = 0; i < 3; i++) iss(1'b0, 1'b0, 32'd3, 32'(i + 2), 5'(10 + i));
    cyc(1'b1, 1'b0, 1'b0, 32'd9, 32'd9, 5'd13, 1'b0, 1'b1, 1'b1);
    #1 chk("flush_cnt", 64'(bus.mul_inflight), 64'd0);
    idle(6);
    iss(1'b0, 1'b0, 32'd11, 32'd12, 5'd14);
    idle(3);
    #1 chk("post_flush_val", 64'(bus.mul_wb_wbvalue), 64'd132);

    // Destination zero never writes the register file.
    iss(1'b0, 1'b0, 32'd5, 32'd6, 5'd0);
    idle(3);
    #1;
    chk("dst0_oper", 64'(bus.mul_wb_oper), 64'd1);
    chk("dst0_wr", 64'(bus.mul_wb_writereg), 64'd0);
    chk("dst0_val", 64'(bus.mul_wb_wbvalue), 64'h0000_001E);

    // One-cycle reset with two operations in flight.
    iss(1'b0, 1'b0, 32'd7, 32'd7, 5'd3);
    iss(1'b0, 1'b0, 32'd8, 32'd8, 5'd4);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_oper", 64'(bus.mul_wb_oper), 64'd0);
    chk("rst_dst", 64'(bus.mul_wb_regdest), 64'd0);
    chk("rst_val", 64'(bus.mul_wb_wbvalue), 64'd0);
    chk("rst_cnt", 64'(bus.mul_inflight), 64'd0);
    idle(6);

    // Randomized traffic; an issue refused by a stall is re-presented unchanged.
    need_new = 1'b1;
    h_op = 1'b0; h_sgn = 1'b0; h_hi = 1'b0; h_a = '0; h_b = '0; h_d = '0;
    for (int n = 0; n < 2000; n++) begin
      if (need_new) begin
        h_op  = ($urandom_range(3) != 0);
        h_sgn = 1'($urandom_range(1));
        h_hi  = 1'($urandom_range(1));
        h_a   = pick();
        h_b   = pick();
        h_d   = REGW'($urandom_range(31));
      end
      st = ($urandom_range(4) == 0);
      fl = ($urandom_range(29) == 0);
      rs = ($urandom_range(199) != 0);
      cyc(h_op, h_sgn, h_hi, h_a, h_b, h_d, st, fl, rs);
      need_new = !st || fl || !rs;
    end
    idle(STAGES + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
